data_mem: RTL and testbench
===========================

DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter Ncores, default 2, number of core ports; only value 2 is supported (ports 0 and 1).
REQ-002 Parameter Lmem, default 8, address bits used; depth = 2^Lmem words (256 at default).
REQ-003 Parameter TAM, default 16, data and address bus width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 dataIN0  input  TAM  write data, port 0.
REQ-007 dataIN1  input  TAM  write data, port 1.
REQ-008 dataADDR0  input  TAM  word address, port 0.
REQ-009 dataADDR1  input  TAM  word address, port 1.
REQ-010 dataWrite  input  Ncores  write enable; bit n selects port n.
REQ-011 dataLoad  input  Ncores  read (load) enable; bit n selects port n.
REQ-012 dataOUT0  output  TAM  registered read data, port 0.
REQ-013 dataOUT1  output  TAM  registered read data, port 1.

Function
REQ-014 Storage SHALL be a 2^Lmem x TAM array shared by both ports.
REQ-015 Effective address SHALL be dataADDRn[Lmem-1:0]; upper address bits are ignored, so addresses wrap modulo 2^Lmem (0x1FF -> 0xFF, 0x100 -> 0x00).
REQ-016 Write: at a rising edge with rst high and dataWrite[n]=1, mem[addrn] SHALL take dataINn.
REQ-017 Read: at a rising edge with rst high and dataLoad[n]=1, dataOUTn SHALL take the word at addrn; read latency is one clock, valid immediately after that edge.
REQ-018 With dataLoad[n]=0, dataOUTn SHALL hold its previous value.
REQ-019 Reads SHALL be write-first: a read of an address written in the same edge, by the same or the other port, SHALL return the newly written data.
REQ-020 Both ports writing the same effective address in the same edge: port 0 data SHALL be stored and returned by any same-edge read of that address; different addresses are written independently.
REQ-021 dataWrite and dataLoad both set on one port SHALL perform both the write and the write-first read.
REQ-022 No handshake or stall exists; every request completes in the cycle it is presented.

Reset
REQ-023 At a rising edge with rst=0, dataOUT0 and dataOUT1 SHALL become 0, and all reads and writes are suppressed.
REQ-024 Memory contents SHALL be retained through reset and SHALL NOT be cleared.
REQ-025 The first edge with rst=1 SHALL process requests normally, with no extra latency.

Verification
REQ-026 Write/read back: rst=1; edge 1: write 0x0001 to addr 0x10 on port 0 and 0x0002 to addr 0x20 on port 1; edge 2: load both ports at the same addresses -> dataOUT0=0x0001 and dataOUT1=0x0002 after edge 2.
REQ-027 Wrap: write 0xBEEF at dataADDR0=0x01FF, then load dataADDR1=0x00FF -> dataOUT1=0xBEEF.
REQ-028 Hold: after REQ-026, deassert dataLoad for 3 edges while changing addresses -> outputs remain 0x0001 and 0x0002.
REQ-029 Collision: both ports write addr 0x05 (port 0 0xAAAA, port 1 0x5555) with dataLoad=2'b11 at 0x05 -> both outputs 0xAAAA, and a later read of 0x05 returns 0xAAAA.
REQ-030 Reset: with outputs nonzero, hold rst=0 for one edge while dataLoad=2'b11 and dataWrite=2'b11 -> outputs become 0x0000 and memory is unchanged; after releasing reset, reading addr 0x10 returns 0x0001.
REQ-031 Random: 1000 iterations of random write-then-read pairs on both ports with distinct addresses -> every read equals the data last written to that address.

Source files
------------

// File: rtl/data_mem_if.sv
// Bus bundle for the dual-port data memory: per-port write data, address,
// write/load enables and registered read data.
interface data_mem_if #(
    parameter int Ncores = 2,
    parameter int TAM    = 16
);
    logic [TAM-1:0]    dataIN0;
    logic [TAM-1:0]    dataIN1;
    logic [TAM-1:0]    dataADDR0;
    logic [TAM-1:0]    dataADDR1;
    logic [Ncores-1:0] dataWrite;
    logic [Ncores-1:0] dataLoad;
    logic [TAM-1:0]    dataOUT0;
    logic [TAM-1:0]    dataOUT1;

    modport master (
        output dataIN0, dataIN1, dataADDR0, dataADDR1, dataWrite, dataLoad,
        input  dataOUT0, dataOUT1
    );

    modport slave (
        input  dataIN0, dataIN1, dataADDR0, dataADDR1, dataWrite, dataLoad,
        output dataOUT0, dataOUT1
    );
endinterface

// File: rtl/data_mem.sv
// Two-port shared data memory, write-first reads with one-cycle latency.
// On a same-address double write, port 0 wins for both storage and forwarding.
module data_mem #(
    parameter int Ncores = 2,
    parameter int Lmem   = 8,
    parameter int TAM    = 16
) (
    input  logic         clk,
    input  logic         rst,
    data_mem_if.slave    bus
);
    localparam int DEPTH = 2 ** Lmem;

    logic [TAM-1:0]  mem_r [DEPTH];
    logic [TAM-1:0]  out0_r;
    logic [TAM-1:0]  out1_r;
    logic [Lmem-1:0] addr0_s;
    logic [Lmem-1:0] addr1_s;
    logic            we0_s;
    logic            we1_s;
    logic            ld0_s;
    logic            ld1_s;
    logic            same_addr_s;
    logic [TAM-1:0]  rd0_s;
    logic [TAM-1:0]  rd1_s;
    logic            unused_addr_s;

    // Upper address bits are dropped so addresses wrap modulo the depth.
    assign addr0_s       = bus.dataADDR0[Lmem-1:0];
    assign addr1_s       = bus.dataADDR1[Lmem-1:0];
    assign unused_addr_s = ^{bus.dataADDR0[TAM-1:Lmem], bus.dataADDR1[TAM-1:Lmem]};
    assign we0_s         = bus.dataWrite[0];
    assign we1_s         = bus.dataWrite[1];
    assign ld0_s         = bus.dataLoad[0];
    assign ld1_s         = bus.dataLoad[1];
    assign same_addr_s   = (addr0_s == addr1_s);

    // Write-first forwarding of same-edge write data, port 0 taking priority.
    always_comb begin
        rd0_s = mem_r[addr0_s];
        rd1_s = mem_r[addr1_s];
        if (we0_s) begin
            rd0_s = bus.dataIN0;
        end else if (we1_s && same_addr_s) begin
            rd0_s = bus.dataIN1;
        end else begin
            rd0_s = mem_r[addr0_s];
        end
        if (we0_s && same_addr_s) begin
            rd1_s = bus.dataIN0;
        end else if (we1_s) begin
            rd1_s = bus.dataIN1;
        end else begin
            rd1_s = mem_r[addr1_s];
        end
    end

    // Storage array; contents survive reset, writes are only blocked during it.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (we0_s) begin
                mem_r[addr0_s] <= bus.dataIN0;
            end
            if (we1_s && !(we0_s && same_addr_s)) begin
                mem_r[addr1_s] <= bus.dataIN1;
            end
        end
    end

    // Registered read data, cleared by reset and held when not loading.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out0_r <= {TAM{1'b0}};
            out1_r <= {TAM{1'b0}};
        end else begin
            if (ld0_s) begin
                out0_r <= rd0_s;
            end
            if (ld1_s) begin
                out1_r <= rd1_s;
            end
        end
    end

    assign bus.dataOUT0 = out0_r;
    assign bus.dataOUT1 = out1_r;
endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: stimulus pushes expected read data per port,
// a monitor pops and compares just after each rising edge.
module tb_data_mem;
    typedef struct {
        logic [15:0] val;
        string       name;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   stim_done;
    exp_t q0[$];
    exp_t q1[$];

    data_mem_if #(.Ncores(2), .TAM(16)) bus ();

    data_mem #(.Ncores(2), .Lmem(8), .TAM(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one edge worth of stimulus and queue what each checked port must show after it.
    task automatic step(input logic r, input logic [1:0] w, input logic [1:0] l,
                        input logic [15:0] a0, input logic [15:0] d0,
                        input logic [15:0] a1, input logic [15:0] d1,
                        input logic c0, input logic [15:0] e0,
                        input logic c1, input logic [15:0] e1,
                        input string name);
        exp_t e;
        @(negedge clk);
        rst           = r;
        bus.dataWrite = w;
        bus.dataLoad  = l;
        bus.dataADDR0 = a0;
        bus.dataIN0   = d0;
        bus.dataADDR1 = a1;
        bus.dataIN1   = d1;
        if (c0) begin
            e.val = e0; e.name = {name, "_p0"};
            q0.push_back(e);
        end
        if (c1) begin
            e.val = e1; e.name = {name, "_p1"};
            q1.push_back(e);
        end
    endtask

    // Monitor: outputs are registered, so compare 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (q0.size() > 0) begin
                e = q0.pop_front();
                checks++;
                if (bus.dataOUT0 !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, bus.dataOUT0, e.val);
                end
            end
            while (q1.size() > 0) begin
                e = q1.pop_front();
                checks++;
                if (bus.dataOUT1 !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, bus.dataOUT1, e.val);
                end
            end
        end
    end

    initial begin
        logic [15:0] ra0, ra1, rd0, rd1;
        checks = 0;
        errors = 0;
        stim_done = 1'b0;
        rst = 1'b0;
        bus.dataWrite = 2'b00; bus.dataLoad = 2'b00;
        bus.dataADDR0 = 16'h0; bus.dataADDR1 = 16'h0;
        bus.dataIN0 = 16'h0;   bus.dataIN1 = 16'h0;

        step(1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
             1'b1, 16'h0000, 1'b1, 16'h0000, "reset_state");
        // Write then read back on both ports; first edge after reset is live.
        step(1'b1, 2'b11, 2'b00, 16'h0010, 16'h0001, 16'h0020, 16'h0002,
             1'b1, 16'h0000, 1'b1, 16'h0000, "write_no_load");
        step(1'b1, 2'b00, 2'b11, 16'h0010, 16'h0000, 16'h0020, 16'h0000,
             1'b1, 16'h0001, 1'b1, 16'h0002, "readback");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b00, 2'b00, 16'h0030 + 16'(i), 16'h0000, 16'h0040 + 16'(i), 16'h0000,
                 1'b1, 16'h0001, 1'b1, 16'h0002, "hold");
        end
        // Address wrap in both directions.
        step(1'b1, 2'b01, 2'b00, 16'h01FF, 16'hBEEF, 16'h0000, 16'h0000,
             1'b0, 16'h0000, 1'b0, 16'h0000, "wrap_wr");
        step(1'b1, 2'b00, 2'b10, 16'h0000, 16'h0000, 16'h00FF, 16'h0000,
             1'b1, 16'h0001, 1'b1, 16'hBEEF, "wrap_1ff");
        step(1'b1, 2'b10, 2'b00, 16'h0000, 16'h0000, 16'h0100, 16'h1234,
             1'b0, 16'h0000, 1'b0, 16'h0000, "wrap_wr2");
        step(1'b1, 2'b00, 2'b01, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
             1'b1, 16'h1234, 1'b1, 16'hBEEF, "wrap_100");
        // Write-first forwarding: same port, and across ports both directions.
        step(1'b1, 2'b01, 2'b01, 16'h0033, 16'hC0DE, 16'h0000, 16'h0000,
             1'b1, 16'hC0DE, 1'b0, 16'h0000, "fwd_same");
        step(1'b1, 2'b10, 2'b01, 16'h0044, 16'h0000, 16'h0044, 16'h7777,
             1'b1, 16'h7777, 1'b0, 16'h0000, "fwd_1to0");
        step(1'b1, 2'b01, 2'b10, 16'h0055, 16'h6666, 16'h0155, 16'h0000,
             1'b0, 16'h0000, 1'b1, 16'h6666, "fwd_0to1");
        // Same-address double write: port 0 wins, also for forwarding.
        step(1'b1, 2'b11, 2'b11, 16'h0005, 16'hAAAA, 16'h0005, 16'h5555,
             1'b1, 16'hAAAA, 1'b1, 16'hAAAA, "collide");
        step(1'b1, 2'b00, 2'b11, 16'h0005, 16'h0000, 16'h0105, 16'h0000,
             1'b1, 16'hAAAA, 1'b1, 16'hAAAA, "collide_later");
        // Reset with live requests: outputs clear, writes suppressed.
        step(1'b0, 2'b11, 2'b11, 16'h0010, 16'hFFFF, 16'h0020, 16'hEEEE,
             1'b1, 16'h0000, 1'b1, 16'h0000, "reset_clear");
        step(1'b1, 2'b00, 2'b11, 16'h0010, 16'h0000, 16'h0020, 16'h0000,
             1'b1, 16'h0001, 1'b1, 16'h0002, "reset_retain");

        // Random write-then-read pairs on distinct addresses, read back crosswise.
        for (int i = 0; i < 1000; i++) begin
            ra0 = 16'($urandom);
            ra1 = 16'($urandom);
            while (ra1[7:0] == ra0[7:0]) ra1 = 16'($urandom);
            rd0 = 16'($urandom);
            rd1 = 16'($urandom);
            step(1'b1, 2'b11, 2'b00, ra0, rd0, ra1, rd1,
                 1'b0, 16'h0000, 1'b0, 16'h0000, "rand_wr");
            step(1'b1, 2'b00, 2'b11, ra1, 16'h0000, ra0, 16'h0000,
                 1'b1, rd1, 1'b1, rd0, "rand_rd");
        end

        step(1'b1, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
             1'b0, 16'h0000, 1'b0, 16'h0000, "idle");
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
        end
        stim_done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        if (!stim_done) begin
            $display("FAIL watchdog: got timeout expected completion");
            errors++;
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $fatal(1, "timeout");
        end
    end
endmodule
